io_bus_responder: RTL and testbench
===================================

Name: io_bus_responder

Overview:
- Memory-mapped I/O responder on the processor's data bus.
- Decodes CPU load/store accesses to the I/O address window and holds the HEX and LEDR output registers.
- Synchronises KEY, and synchronises and debounces SW.
- Exposes sticky ready/overrun status so software can poll for input changes.
- Sits beside data memory. The CPU selects bus_rdata over memory data whenever bus_hit is high.

Parameters:
DBITS, 32, bus data/address width
ADDR_HEX, 32'hF0000000, HEX display register (RW)
ADDR_LEDR, 32'hF0000004, red LED register (RW)
ADDR_KEY, 32'hF0000010, KDATA key state (RO)
ADDR_SW, 32'hF0000014, SDATA switch state (RO)
ADDR_KCTRL, 32'hF0000110, key status (bit0 ready RO, bit2 overrun RW0C)
ADDR_SCTRL, 32'hF0000114, switch status (same layout as KCTRL)
DEBOUNCE_CYCLES, 100000, consecutive stable cycles before an SW change is accepted (must be >=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
bus_req  in  1  access strobe, one cycle per access
bus_we  in  1  1=store, 0=load
bus_addr  in  DBITS  byte address
bus_wdata  in  DBITS  store data
bus_hit  out  1  combinational: bus_addr matches any mapped register
bus_rdata  out  DBITS  registered load data
bus_rvalid  out  1  high exactly one cycle after an accepted load
KEY  in  4  board keys, active-low
SW  in  10  board switches
LEDR  out  10  LED register
HEX0..HEX3  out  7 each  seven-segment outputs, active-low

Behaviour:
- Reset (reset==0 at a clk edge): all of the following clear to 0: HEX reg (16b), LEDR reg, KDATA, SDATA, both ready bits, both overrun bits, debounce counter, bus_rdata, bus_rvalid. Synchroniser flops load the idle values (KEY=4'hF, SW=0).
- Reset applied mid-access cancels the access: bus_rvalid is 0 on the cycle after reset.
- Load (bus_req & ~bus_we & bus_hit): bus_rdata updates on the next edge and bus_rvalid is 1 for that one cycle. Latency is exactly 1.
  - KDATA reads as {28'b0, kdata}.
  - SDATA reads as {22'b0, sdata}.
  - CTRL registers read as {29'b0, overrun, 1'b0, ready}.
  - HEX and LEDR read back as zero-extended values.
- Unmapped access: bus_hit=0, no rvalid, no state change.
- Store: takes effect at the next edge.
  - HEX reg <= wdata[15:0].
  - LEDR <= wdata[9:0].
  - KCTRL/SCTRL: writing 0 to bit2 clears overrun; all other bits are ignored.
  - Stores to KDATA/SDATA are ignored.
- KEY path: 2-flop synchroniser, inverted (pressed=1).
  - When the synced value != kdata: kdata <= synced and ready <= 1.
  - overrun <= 1 if ready was already 1.
- SW path: 2-flop synchroniser feeding a candidate register and a counter.
  - Counter resets to 0 whenever synced != candidate (candidate <= synced); otherwise it increments, saturating at DEBOUNCE_CYCLES-1.
  - When the counter reaches DEBOUNCE_CYCLES-1 and candidate != sdata: sdata <= candidate and ready/overrun update as for keys.
- A load of KDATA (SDATA) clears the key (switch) ready bit.
- A load of KDATA and a new key change in the same cycle: change wins. ready stays 1 and overrun is not set. The same rule applies to switches.
- A store clearing overrun and an overrun event in the same cycle: the event wins (overrun=1).
- HEX outputs: digit n is driven from HEX reg nibble n (HEX0 = bits[3:0]); see Optional Feature for encoding.

Optional Feature:
- Macro: IO_HEX_DECODE_EN.
- Defined: each nibble is decoded to the active-low 0-F font, e.g. 0 -> 7'b1000000, A -> 7'b0001000. After reset, all digits show "0".
- Undefined: each HEXn outputs the nibble as raw bits, i.e. HEXn = ~{3'b000, nibble}. There is no decoder logic; after reset all outputs are 7'h7F.
- Register map and bus behaviour are identical in both builds.

Test Plan:
1. Reset low for 2 cycles, then store 32'h0000BEEF to ADDR_HEX and 32'h3FF to ADDR_LEDR -> LEDR=10'h3FF; HEX0..3 decode F,E,E,B (decode build); a load of ADDR_HEX returns 32'h0000BEEF with rvalid exactly 1 cycle after req.
2. KEY goes 4'hF->4'hE -> after sync, KCTRL reads 1. Load KDATA -> returns 1, and the next KCTRL read returns 0.
3. Two key changes without an intervening KDATA read -> KCTRL reads 5. Store 0 to KCTRL -> reads 1. A KDATA read in the same cycle as a new change -> KCTRL stays 1.
4. DEBOUNCE_CYCLES=8: SW toggles 10'h001 every 5 cycles, then holds -> SDATA unchanged during toggling; updates to 10'h001 8 cycles after hold plus sync latency; SCTRL ready=1.
5. Load of 32'hF0000018 and 32'h00000040 -> bus_hit=0, no rvalid, all state unchanged.
6. Assert reset in the cycle after a KDATA load request -> rvalid=0 next cycle; all registers return to reset values.

Source files
------------

// File: rtl/io_bus_responder_if.sv
// Processor data-bus interface between the CPU (master) and an I/O responder (slave).
// Latency: none here. The responder returns load data one cycle after the request.
// Backpressure: none. The slave accepts every request strobe.
interface io_bus_responder_if #(
    parameter int DBITS = 32
) ();
    logic             bus_req;
    logic             bus_we;
    logic [DBITS-1:0] bus_addr;
    logic [DBITS-1:0] bus_wdata;
    logic             bus_hit;
    logic [DBITS-1:0] bus_rdata;
    logic             bus_rvalid;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_hit, bus_rdata, bus_rvalid
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_hit, bus_rdata, bus_rvalid
    );
endinterface

// File: rtl/io_bus_responder.sv
// Memory-mapped I/O responder: HEX/LEDR registers, synchronised KEY, debounced SW, sticky ready/overrun status.
// Latency: bus_hit is combinational; load data and rvalid arrive 1 cycle after the request; stores land at the next edge.
// Backpressure: none. Every request is accepted. Define IO_HEX_DECODE_EN for 7-segment font decoding of the HEX digits.
module io_bus_responder #(
    parameter int               DBITS           = 32,
    parameter logic [DBITS-1:0] ADDR_HEX        = 32'hF0000000,
    parameter logic [DBITS-1:0] ADDR_LEDR       = 32'hF0000004,
    parameter logic [DBITS-1:0] ADDR_KEY        = 32'hF0000010,
    parameter logic [DBITS-1:0] ADDR_SW         = 32'hF0000014,
    parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF0000110,
    parameter logic [DBITS-1:0] ADDR_SCTRL      = 32'hF0000114,
    parameter int               DEBOUNCE_CYCLES = 100000
) (
    input  logic                clk,
    input  logic                reset,
    io_bus_responder_if.slave   bus,
    input  logic [3:0]          KEY,
    input  logic [9:0]          SW,
    output logic [9:0]          LEDR,
    output logic [6:0]          HEX0,
    output logic [6:0]          HEX1,
    output logic [6:0]          HEX2,
    output logic [6:0]          HEX3
);
    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [15:0]      hex_q,     hex_d;
    logic [9:0]       ledr_q,    ledr_d;
    logic [3:0]       key_s1_q,  key_s1_d, key_s2_q, key_s2_d;
    logic [3:0]       kdata_q,   kdata_d;
    logic             kready_q,  kready_d, kovr_q, kovr_d;
    logic [9:0]       sw_s1_q,   sw_s1_d,  sw_s2_q,  sw_s2_d;
    logic [9:0]       sw_cand_q, sw_cand_d;
    logic [CW-1:0]    db_cnt_q,  db_cnt_d;
    logic [9:0]       sdata_q,   sdata_d;
    logic             sready_q,  sready_d, sovr_q, sovr_d;
    logic [DBITS-1:0] rdata_q,   rdata_d;
    logic             rvalid_q,  rvalid_d;

    logic sel_hex, sel_ledr, sel_key, sel_sw, sel_kctrl, sel_sctrl;
    logic hit, ld, st, key_chg, sw_chg;
    logic [3:0]       key_synced;
    logic [DBITS-1:0] rdata_mux;
    logic             unused_wdata;

    // Only the low 16 store-data bits carry register contents.
    assign unused_wdata = ^bus.bus_wdata[DBITS-1:16];

    // Address decode, read mux and next-state for every register.
    always_comb begin
        sel_hex   = (bus.bus_addr == ADDR_HEX);
        sel_ledr  = (bus.bus_addr == ADDR_LEDR);
        sel_key   = (bus.bus_addr == ADDR_KEY);
        sel_sw    = (bus.bus_addr == ADDR_SW);
        sel_kctrl = (bus.bus_addr == ADDR_KCTRL);
        sel_sctrl = (bus.bus_addr == ADDR_SCTRL);
        hit       = sel_hex | sel_ledr | sel_key | sel_sw | sel_kctrl | sel_sctrl;
        ld        = bus.bus_req & ~bus.bus_we & hit;
        st        = bus.bus_req &  bus.bus_we;

        rdata_mux = '0;
        if (sel_hex)   rdata_mux = DBITS'(hex_q);
        if (sel_ledr)  rdata_mux = DBITS'(ledr_q);
        if (sel_key)   rdata_mux = DBITS'(kdata_q);
        if (sel_sw)    rdata_mux = DBITS'(sdata_q);
        if (sel_kctrl) rdata_mux = DBITS'({kovr_q, 1'b0, kready_q});
        if (sel_sctrl) rdata_mux = DBITS'({sovr_q, 1'b0, sready_q});

        rdata_d  = ld ? rdata_mux : rdata_q;
        rvalid_d = ld;

        hex_d  = (st && sel_hex)  ? bus.bus_wdata[15:0] : hex_q;
        ledr_d = (st && sel_ledr) ? bus.bus_wdata[9:0]  : ledr_q;

        // Keys are active-low on the board; internally pressed = 1.
        key_s1_d   = KEY;
        key_s2_d   = key_s1_q;
        key_synced = ~key_s2_q;
        key_chg    = (key_synced != kdata_q);
        kdata_d    = key_chg ? key_synced : kdata_q;
        kready_d   = kready_q;
        if (ld && sel_key) kready_d = 1'b0;
        if (key_chg)       kready_d = 1'b1;
        // A change that coincides with a KDATA read is not an overrun: the old value was consumed.
        kovr_d = kovr_q;
        if (st && sel_kctrl && !bus.bus_wdata[2]) kovr_d = 1'b0;
        if (key_chg && kready_q && !(ld && sel_key)) kovr_d = 1'b1;

        // Switch debounce: candidate must stay put for DEBOUNCE_CYCLES cycles.
        sw_s1_d   = SW;
        sw_s2_d   = sw_s1_q;
        sw_cand_d = sw_cand_q;
        db_cnt_d  = db_cnt_q;
        if (sw_s2_q != sw_cand_q) begin
            sw_cand_d = sw_s2_q;
            db_cnt_d  = '0;
        end else if (db_cnt_q != CNT_MAX) begin
            db_cnt_d  = db_cnt_q + CW'(1);
        end
        sw_chg   = (db_cnt_q == CNT_MAX) && (sw_cand_q != sdata_q);
        sdata_d  = sw_chg ? sw_cand_q : sdata_q;
        sready_d = sready_q;
        if (ld && sel_sw) sready_d = 1'b0;
        if (sw_chg)       sready_d = 1'b1;
        sovr_d = sovr_q;
        if (st && sel_sctrl && !bus.bus_wdata[2]) sovr_d = 1'b0;
        if (sw_chg && sready_q && !(ld && sel_sw)) sovr_d = 1'b1;
    end

    // State registers with synchronous active-low reset; synchronisers reset to idle inputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hex_q     <= '0;
            ledr_q    <= '0;
            key_s1_q  <= 4'hF;
            key_s2_q  <= 4'hF;
            kdata_q   <= '0;
            kready_q  <= 1'b0;
            kovr_q    <= 1'b0;
            sw_s1_q   <= '0;
            sw_s2_q   <= '0;
            sw_cand_q <= '0;
            db_cnt_q  <= '0;
            sdata_q   <= '0;
            sready_q  <= 1'b0;
            sovr_q    <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            hex_q     <= hex_d;
            ledr_q    <= ledr_d;
            key_s1_q  <= key_s1_d;
            key_s2_q  <= key_s2_d;
            kdata_q   <= kdata_d;
            kready_q  <= kready_d;
            kovr_q    <= kovr_d;
            sw_s1_q   <= sw_s1_d;
            sw_s2_q   <= sw_s2_d;
            sw_cand_q <= sw_cand_d;
            db_cnt_q  <= db_cnt_d;
            sdata_q   <= sdata_d;
            sready_q  <= sready_d;
            sovr_q    <= sovr_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

`ifdef IO_HEX_DECODE_EN
    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b1000000;  4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;  4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;  4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;  4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;  4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;  default: seg7 = 7'b0001110;
        endcase
    endfunction
`else
    // Raw nibble on the low segments, active-low.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        seg7 = ~{3'b000, n};
    endfunction
`endif

    assign HEX0           = seg7(hex_q[3:0]);
    assign HEX1           = seg7(hex_q[7:4]);
    assign HEX2           = seg7(hex_q[11:8]);
    assign HEX3           = seg7(hex_q[15:12]);
    assign LEDR           = ledr_q;
    assign bus.bus_hit    = hit;
    assign bus.bus_rdata  = rdata_q;
    assign bus.bus_rvalid = rvalid_q;
endmodule

// File: tb/tb_io_bus_responder.sv
// Scoreboard bench for io_bus_responder: loads push expected data, a monitor pops on rvalid.
// Latency: expects each load response exactly one cycle after the request edge.
// Backpressure: none. Inputs are driven on the falling edge and outputs are sampled there too.
module tb_io_bus_responder;
    localparam logic [31:0] A_HEX   = 32'hF0000000;
    localparam logic [31:0] A_LEDR  = 32'hF0000004;
    localparam logic [31:0] A_KEY   = 32'hF0000010;
    localparam logic [31:0] A_SW    = 32'hF0000014;
    localparam logic [31:0] A_KCTRL = 32'hF0000110;
    localparam logic [31:0] A_SCTRL = 32'hF0000114;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] KEY   = 4'hF;
    logic [9:0] SW    = '0;
    logic [9:0] LEDR;
    logic [6:0] HEX0, HEX1, HEX2, HEX3;

    io_bus_responder_if #(.DBITS(32)) bus ();

    io_bus_responder #(.DEBOUNCE_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .bus(bus), .KEY(KEY), .SW(SW),
        .LEDR(LEDR), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
    );

    always #5 clk = ~clk;

    int cyc   = 0;
    int n_vec = 0;
    int n_err = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] data;
        int          due;
        string       name;
    } exp_t;
    exp_t sb[$];

    // Expected 7-segment pattern for one nibble.
    function automatic logic [6:0] seg(input logic [3:0] n);
`ifdef IO_HEX_DECODE_EN
        logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        seg = font[n];
`else
        seg = ~{3'b000, n};
`endif
    endfunction

    // Scoreboard monitor: every rvalid must match the oldest pending load, in the right cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.bus_rvalid === 1'b1) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL spurious_rvalid: got rvalid=1 rdata=%h at cycle %0d, want no response", bus.bus_rdata, cyc);
            end else begin
                e = sb.pop_front();
                if (bus.bus_rdata !== e.data || cyc != e.due) begin
                    n_err++;
                    $display("FAIL %s: got %h at cycle %0d, want %h at cycle %0d", e.name, bus.bus_rdata, cyc, e.data, e.due);
                end
            end
        end else if (sb.size() != 0 && cyc > sb[0].due) begin
            e = sb.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL %s: got no rvalid, want %h at cycle %0d", e.name, e.data, e.due);
        end
    end

    task automatic load(input logic [31:0] a, input logic [31:0] exp, input string nm);
        @(negedge clk);
        bus.bus_req  = 1'b1;
        bus.bus_we   = 1'b0;
        bus.bus_addr = a;
        sb.push_back('{data: exp, due: cyc + 1, name: nm});
        @(posedge clk);
        #1 bus.bus_req = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.bus_req   = 1'b1;
        bus.bus_we    = 1'b1;
        bus.bus_addr  = a;
        bus.bus_wdata = d;
        @(posedge clk);
        #1;
        bus.bus_req = 1'b0;
        bus.bus_we  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (bus.bus_rvalid !== 1'b0 || bus.bus_rdata !== 32'h0 || LEDR !== 10'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got rvalid=%b rdata=%h ledr=%h, want 0 0 0", bus.bus_rvalid, bus.bus_rdata, LEDR);
        end
        n_vec++;
        if ({HEX3, HEX2, HEX1, HEX0} !== {4{seg(4'h0)}}) begin
            n_err++;
            $display("FAIL reset_hex: got %h %h %h %h, want all %h", HEX3, HEX2, HEX1, HEX0, seg(4'h0));
        end
        reset = 1'b1;
        load(A_HEX,   32'h0, "reset_hex_reg");
        load(A_LEDR,  32'h0, "reset_ledr_reg");
        load(A_KEY,   32'h0, "reset_kdata");
        load(A_SW,    32'h0, "reset_sdata");
        load(A_KCTRL, 32'h0, "reset_kctrl");
        load(A_SCTRL, 32'h0, "reset_sctrl");
    endtask

    task automatic test_hex_ledr();
        store(A_HEX,  32'hA5A5BEEF);
        store(A_LEDR, 32'h000003FF);
        @(negedge clk);
        n_vec++;
        if (LEDR !== 10'h3FF) begin
            n_err++;
            $display("FAIL ledr_port: got %h, want 3ff", LEDR);
        end
        n_vec++;
        if ({HEX3, HEX2, HEX1, HEX0} !== {seg(4'hB), seg(4'hE), seg(4'hE), seg(4'hF)}) begin
            n_err++;
            $display("FAIL hex_ports: got %h %h %h %h, want %h %h %h %h", HEX3, HEX2, HEX1, HEX0,
                     seg(4'hB), seg(4'hE), seg(4'hE), seg(4'hF));
        end
        load(A_HEX,  32'h0000BEEF, "hex_readback");
        load(A_LEDR, 32'h000003FF, "ledr_readback");
    endtask

    task automatic test_key_basic();
        @(negedge clk) KEY = 4'hE;
        repeat (4) @(posedge clk);
        load(A_KCTRL, 32'h1, "key_ready_set");
        load(A_KEY,   32'h1, "key_kdata");
        load(A_KCTRL, 32'h0, "key_ready_cleared");
    endtask

    task automatic test_key_overrun();
        @(negedge clk) KEY = 4'hC;
        repeat (4) @(posedge clk);
        @(negedge clk) KEY = 4'h8;
        repeat (4) @(posedge clk);
        load(A_KCTRL, 32'h5, "key_overrun_set");
        store(A_KCTRL, 32'h4);
        load(A_KCTRL, 32'h5, "key_overrun_kept_on_w1");
        store(A_KCTRL, 32'h0);
        load(A_KCTRL, 32'h1, "key_overrun_cleared");
        // KDATA read lands on the same edge as the next key change.
        @(negedge clk) KEY = 4'h0;
        @(posedge clk);
        @(posedge clk);
        load(A_KEY,   32'h7, "key_read_during_change");
        load(A_KCTRL, 32'h1, "key_change_beats_read");
        load(A_KEY,   32'hF, "key_new_value");
        @(negedge clk) KEY = 4'h1;
        repeat (4) @(posedge clk);
        // Overrun-clearing store lands on the same edge as an overrun event.
        @(negedge clk) KEY = 4'h3;
        @(posedge clk);
        @(posedge clk);
        store(A_KCTRL, 32'h0);
        load(A_KCTRL, 32'h5, "key_event_beats_clear");
        load(A_KEY,   32'hC, "key_final_value");
    endtask

    task automatic test_sw_debounce();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk) SW = (i % 2 == 0) ? 10'h001 : 10'h000;
            repeat (3) @(posedge clk);
            load(A_SW, 32'h0, "sw_toggle_ignored");
        end
        @(negedge clk) SW = 10'h001;
        repeat (9) @(posedge clk);
        load(A_SW,    32'h0, "sw_not_yet_stable_a");
        load(A_SW,    32'h0, "sw_not_yet_stable_b");
        load(A_SCTRL, 32'h1, "sw_ready_set");
        load(A_SW,    32'h1, "sw_sdata_updated");
        load(A_SCTRL, 32'h0, "sw_ready_cleared");
    endtask

    task automatic test_unmapped();
        logic [31:0] addrs [3] = '{32'hF0000018, 32'h00000040, 32'hF0000008};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.bus_req   = 1'b1;
            bus.bus_we    = (i == 2);
            bus.bus_addr  = addrs[i];
            bus.bus_wdata = 32'h0;
            #1;
            n_vec++;
            if (bus.bus_hit !== 1'b0) begin
                n_err++;
                $display("FAIL unmapped_hit: got %b for addr %h, want 0", bus.bus_hit, addrs[i]);
            end
            @(posedge clk);
            #1;
            bus.bus_req = 1'b0;
            bus.bus_we  = 1'b0;
        end
        @(negedge clk) bus.bus_addr = A_SCTRL;
        #1;
        n_vec++;
        if (bus.bus_hit !== 1'b1) begin
            n_err++;
            $display("FAIL mapped_hit: got %b, want 1", bus.bus_hit);
        end
        store(A_KEY, 32'hFFFFFFFF);
        store(A_SW,  32'hFFFFFFFF);
        load(A_HEX,  32'h0000BEEF, "unmapped_hex_kept");
        load(A_LEDR, 32'h000003FF, "unmapped_ledr_kept");
        load(A_KEY,  32'hC,        "ro_kdata_kept");
        load(A_SW,   32'h1,        "ro_sdata_kept");
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        KEY = 4'hF;
        SW  = 10'h000;
        // Request and reset share an edge: no response may appear.
        @(negedge clk);
        bus.bus_req  = 1'b1;
        bus.bus_we   = 1'b0;
        bus.bus_addr = A_KEY;
        reset        = 1'b0;
        @(posedge clk);
        #1 bus.bus_req = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.bus_rvalid !== 1'b0 || LEDR !== 10'h0) begin
            n_err++;
            $display("FAIL reset_cancel: got rvalid=%b ledr=%h, want 0 0", bus.bus_rvalid, LEDR);
        end
        n_vec++;
        if ({HEX3, HEX2, HEX1, HEX0} !== {4{seg(4'h0)}}) begin
            n_err++;
            $display("FAIL reset2_hex: got %h %h %h %h, want all %h", HEX3, HEX2, HEX1, HEX0, seg(4'h0));
        end
        @(posedge clk);
        #1 reset = 1'b1;
        load(A_HEX,   32'h0, "reset2_hex_reg");
        load(A_LEDR,  32'h0, "reset2_ledr_reg");
        load(A_KEY,   32'h0, "reset2_kdata");
        load(A_SW,    32'h0, "reset2_sdata");
        load(A_KCTRL, 32'h0, "reset2_kctrl");
        load(A_SCTRL, 32'h0, "reset2_sctrl");
    endtask

    initial begin
        bus.bus_req   = 1'b0;
        bus.bus_we    = 1'b0;
        bus.bus_addr  = '0;
        bus.bus_wdata = '0;
        test_reset();
        test_hex_ledr();
        test_key_basic();
        test_key_overrun();
        test_sw_debounce();
        test_unmapped();
        test_reset_mid_access();
        repeat (4) @(negedge clk);
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL %s: got no rvalid before end, want %h", e.name, e.data);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
